// File: rtl/lib_switch_onehot_buffered_pkg.sv
// Shared types and helpers for the buffered one-hot crossbar: packet format,
// FIFO width helpers and select decode functions.
package lib_switch_onehot_buffered_pkg;

    typedef struct packed {
        logic [3:0]  dest;
        logic [27:0] payload;
    } packet_t;

    localparam int PKT_W      = $bits(packet_t);
    localparam int DEPTH_DFLT = 4;
    localparam int SEL_MAX_W  = 32;
    localparam logic [SEL_MAX_W-1:0] SEL_ONE = 1;

    // A single-entry FIFO still needs a one-bit pointer register.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PTR_W = ptr_width(DEPTH_DFLT);
    localparam int CNT_W = cnt_width(DEPTH_DFLT);

    function automatic logic sel_is_onehot(input logic [SEL_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - SEL_ONE)) == '0);
    endfunction

    function automatic logic sel_is_multihot(input logic [SEL_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - SEL_ONE)) != '0);
    endfunction

    function automatic int sel_index(input logic [SEL_MAX_W-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < SEL_MAX_W; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/lib_switch_onehot_buffered_if.sv
// Handshake bundle of the buffered crossbar: select, input packets with
// valid/ready, and output FIFO heads with valid/ready.
interface lib_switch_onehot_buffered_if #(
    parameter int N = 4,
    parameter int M = 4
);
    import lib_switch_onehot_buffered_pkg::*;

    logic    [0:M-1][0:N-1] i_sel;
    packet_t [0:N-1]        i_data;
    logic    [0:N-1]        i_in_valid;
    logic    [0:N-1]        o_in_ready;
    packet_t [0:M-1]        o_data;
    logic    [0:M-1]        o_out_valid;
    logic    [0:M-1]        i_out_ready;

    modport master (
        output i_sel, i_data, i_in_valid, i_out_ready,
        input  o_in_ready, o_data, o_out_valid
    );

    modport slave (
        input  i_sel, i_data, i_in_valid, i_out_ready,
        output o_in_ready, o_data, o_out_valid
    );

endinterface

// File: rtl/lib_switch_onehot_buffered_fifo.sv
// Single-clock packet FIFO with a registered head; any DEPTH >= 1, pointers
// wrap explicitly so non-power-of-two depths work.
module lib_fifo_packet_t
    import lib_switch_onehot_buffered_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = ptr_width(DEPTH),
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  packet_t       wdata_i,
    output packet_t       head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    packet_t       mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    packet_t       head_q, head_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push_i && (count_q != CNT_FULL);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        // The head register tracks the entry at the post-edge read pointer;
        // when that entry is being written this edge, take it from wdata.
        head_d = head_q;
        if (count_q == '0) begin
            if (do_push) head_d = wdata_i;
        end else if (do_pop) begin
            if (count_q == CNT_ONE) begin
                if (do_push) head_d = wdata_i;
            end else begin
                head_d = mem_q[ptr_inc(rd_ptr_q)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/lib_switch_onehot_buffered.sv
// NxM packet crossbar with per-output one-hot select, atomic multicast and a
// DEPTH-entry FIFO per output. Optional select checking: LIB_SWITCH_SEL_CHECK_EN.
module lib_switch_onehot_buffered
    import lib_switch_onehot_buffered_pkg::*;
#(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
`ifdef LIB_SWITCH_SEL_CHECK_EN
    output logic [0:M-1]                  o_sel_err,
    output logic [15:0]                   o_sel_err_cnt,
`endif
    lib_switch_onehot_buffered_if.slave   sw
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic          sel_ok    [M];
    int            sel_idx   [M];
    logic [CW-1:0] count     [M];
    packet_t       head      [M];
    logic          out_valid [M];
    logic          push      [M];
    logic          pop       [M];
    packet_t       wdata     [M];
    logic [0:N-1]  has_tgt, has_room, in_ready;
`ifdef LIB_SWITCH_SEL_CHECK_EN
    logic          sel_multi [M];
`endif

    for (genvar m = 0; m < M; m++) begin : g_out
        logic [SEL_MAX_W-1:0] sel_ext;

        always_comb begin
            sel_ext = '0;
            for (int n = 0; n < N; n++) sel_ext[n] = sw.i_sel[m][n];
        end

        assign sel_ok[m]  = sel_is_onehot(sel_ext);
        assign sel_idx[m] = sel_index(sel_ext);
`ifdef LIB_SWITCH_SEL_CHECK_EN
        assign sel_multi[m] = sel_is_multihot(sel_ext);
`endif

        lib_fifo_packet_t #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push_i  (push[m]),
            .pop_i   (pop[m]),
            .wdata_i (wdata[m]),
            .head_o  (head[m]),
            .valid_o (out_valid[m]),
            .count_o (count[m])
        );
    end

    // An input is ready only if every output selecting it has room before
    // the edge, which keeps multicast all-or-nothing.
    always_comb begin
        has_tgt  = '0;
        has_room = '1;
        for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
                if (sel_ok[m] && sel_idx[m] == n) begin
                    has_tgt[n] = 1'b1;
                    if (count[m] >= CNT_FULL) has_room[n] = 1'b0;
                end
            end
        end
        in_ready = has_tgt & has_room & {N{reset_n}};
    end

    always_comb begin
        for (int m = 0; m < M; m++) begin
            push[m]  = 1'b0;
            wdata[m] = '0;
            pop[m]   = out_valid[m] & sw.i_out_ready[m];
            for (int n = 0; n < N; n++) begin
                if (sel_ok[m] && sel_idx[m] == n) begin
                    push[m]  = sw.i_in_valid[n] & in_ready[n];
                    wdata[m] = sw.i_data[n];
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < M; m++) begin
            sw.o_data[m]      = head[m];
            sw.o_out_valid[m] = out_valid[m];
        end
    end

    assign sw.o_in_ready = in_ready;

`ifdef LIB_SWITCH_SEL_CHECK_EN
    logic [0:M-1] sel_err_q, sel_err_d;
    logic [15:0]  sel_err_cnt_q, sel_err_cnt_d;
    logic         any_multi;

    always_comb begin
        sel_err_d = sel_err_q;
        any_multi = 1'b0;
        for (int m = 0; m < M; m++) begin
            if (sel_multi[m]) begin
                sel_err_d[m] = 1'b1;
                any_multi    = 1'b1;
            end
        end
        sel_err_cnt_d = sel_err_cnt_q;
        if (any_multi && sel_err_cnt_q != 16'hFFFF) sel_err_cnt_d = sel_err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_err_q     <= '0;
            sel_err_cnt_q <= '0;
        end else begin
            sel_err_q     <= sel_err_d;
            sel_err_cnt_q <= sel_err_cnt_d;
        end
    end

    assign o_sel_err     = sel_err_q;
    assign o_sel_err_cnt = sel_err_cnt_q;
`endif

endmodule

// File: tb/tb_lib_switch_onehot_buffered.sv
// Bench for the buffered one-hot crossbar: DEPTH=4 and DEPTH=3 instances share
// stimulus and are compared against per-output packet queues.
`timescale 1ns/1ps
module tb_lib_switch_onehot_buffered;
    import lib_switch_onehot_buffered_pkg::*;

    localparam int N = 4;
    localparam int M = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic    [0:M-1][0:N-1] sel;
    packet_t [0:N-1]        din;
    logic    [0:N-1]        vin;
    logic    [0:M-1]        ordy;

    lib_switch_onehot_buffered_if #(.N(N), .M(M)) if4 ();
    lib_switch_onehot_buffered_if #(.N(N), .M(M)) if3 ();

    assign if4.i_sel = sel;  assign if4.i_data = din;  assign if4.i_in_valid = vin;  assign if4.i_out_ready = ordy;
    assign if3.i_sel = sel;  assign if3.i_data = din;  assign if3.i_in_valid = vin;  assign if3.i_out_ready = ordy;

`ifdef LIB_SWITCH_SEL_CHECK_EN
    logic [0:M-1] err4, err3;
    logic [15:0]  ecnt4, ecnt3;
`endif

    lib_switch_onehot_buffered #(.N(N), .M(M), .DEPTH(4)) u_dut4 (
        .clk           (clk),
        .reset_n       (reset_n),
`ifdef LIB_SWITCH_SEL_CHECK_EN
        .o_sel_err     (err4),
        .o_sel_err_cnt (ecnt4),
`endif
        .sw            (if4.slave)
    );

    lib_switch_onehot_buffered #(.N(N), .M(M), .DEPTH(3)) u_dut3 (
        .clk           (clk),
        .reset_n       (reset_n),
`ifdef LIB_SWITCH_SEL_CHECK_EN
        .o_sel_err     (err3),
        .o_sel_err_cnt (ecnt3),
`endif
        .sw            (if3.slave)
    );

    int      checks   = 0;
    int      failures = 0;
    packet_t q [2*M][$];
    bit      after_rst [2];
`ifdef LIB_SWITCH_SEL_CHECK_EN
    logic [0:M-1] err_m;
    int           ecnt_m;
`endif

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int dep(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [0:N-1] act_rdy(input int d);
        return (d == 0) ? if4.o_in_ready : if3.o_in_ready;
    endfunction

    function automatic logic act_ov(input int d, input int m);
        return (d == 0) ? if4.o_out_valid[m] : if3.o_out_valid[m];
    endfunction

    function automatic packet_t act_od(input int d, input int m);
        return (d == 0) ? if4.o_data[m] : if3.o_data[m];
    endfunction

    function automatic packet_t pk(input int unsigned v);
        return packet_t'(v);
    endfunction

    task automatic idle();
        sel  = '0;
        vin  = '0;
        ordy = '0;
        din  = '0;
    endtask

    task automatic route(input int m, input int n);
        sel[m]    = '0;
        sel[m][n] = 1'b1;
    endtask

    // Called just after a falling edge with inputs set; checks the current
    // outputs, advances the reference queues and waits for the next falling edge.
    task automatic cycle();
        logic [0:N-1] exp_rdy [2];
        bit tgt, room;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy[d] = '0;
            for (int n = 0; n < N; n++) begin
                tgt  = 0;
                room = 1;
                for (int m = 0; m < M; m++) begin
                    if ($countones(sel[m]) == 1 && sel[m][n]) begin
                        tgt = 1;
                        if (q[d*M+m].size() >= dep(d)) room = 0;
                    end
                end
                exp_rdy[d][n] = reset_n && tgt && room;
            end
            chk($sformatf("d%0d_in_ready", dep(d)), act_rdy(d), exp_rdy[d]);
            for (int m = 0; m < M; m++) begin
                chk($sformatf("d%0d_out_valid%0d", dep(d), m), act_ov(d, m), q[d*M+m].size() > 0);
                if (q[d*M+m].size() > 0)
                    chk($sformatf("d%0d_out_data%0d", dep(d), m), act_od(d, m), q[d*M+m][0]);
                else if (after_rst[d])
                    chk($sformatf("d%0d_rst_data%0d", dep(d), m), act_od(d, m), 0);
            end
            after_rst[d] = 0;
        end
`ifdef LIB_SWITCH_SEL_CHECK_EN
        chk("d4_sel_err", err4, err_m);
        chk("d3_sel_err", err3, err_m);
        chk("d4_sel_err_cnt", ecnt4, ecnt_m);
        chk("d3_sel_err_cnt", ecnt3, ecnt_m);
`endif
        if (!reset_n) begin
            for (int i = 0; i < 2*M; i++) q[i].delete();
            after_rst[0] = 1;
            after_rst[1] = 1;
`ifdef LIB_SWITCH_SEL_CHECK_EN
            err_m  = '0;
            ecnt_m = 0;
`endif
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < M; m++) begin
                    if (q[d*M+m].size() > 0 && ordy[m]) void'(q[d*M+m].pop_front());
                    if ($countones(sel[m]) == 1) begin
                        for (int n = 0; n < N; n++)
                            if (sel[m][n] && vin[n] && exp_rdy[d][n]) q[d*M+m].push_back(din[n]);
                    end
                end
            end
`ifdef LIB_SWITCH_SEL_CHECK_EN
            begin
                bit any;
                any = 0;
                for (int m = 0; m < M; m++)
                    if ($countones(sel[m]) > 1) begin err_m[m] = 1'b1; any = 1; end
                if (any && ecnt_m < 65535) ecnt_m++;
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        ordy = '1;
        repeat (5) cycle();
    endtask

    initial begin
        int pct;
        int r;
        idle();
        reset_n = 1'b0;
        after_rst[0] = 1;
        after_rst[1] = 1;
`ifdef LIB_SWITCH_SEL_CHECK_EN
        err_m  = '0;
        ecnt_m = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        cycle();
        reset_n = 1'b1;

        // Unicast: output 2 takes input 1.
        idle(); route(2, 1); vin[1] = 1'b1; din[1] = pk(32'hA5A50001); ordy[2] = 1'b1;
        cycle();
        idle();
        chk("uni_valid", if4.o_out_valid, 4'b0010);
        chk("uni_data", if4.o_data[2], 32'hA5A50001);
        cycle();
        drain();

        // Fill output 0 with backpressure, then one pop.
        idle(); route(0, 0);
        for (int k = 0; k < 5; k++) begin
            vin[0] = 1'b1;
            din[0] = pk(32'h100 + k);
            cycle();
        end
        chk("full_rdy", if4.o_in_ready[0], 1'b0);
        vin[0] = 1'b0; ordy[0] = 1'b1;
        #1 chk("pop_cycle_rdy", if4.o_in_ready[0], 1'b0);
        cycle();
        ordy[0] = 1'b0;
        #1 chk("after_pop_rdy", if4.o_in_ready[0], 1'b1);
        cycle();
        drain();

        // Atomic multicast onto outputs 0 and 3 with output 3 full.
        idle(); route(3, 0); vin[0] = 1'b1;
        repeat (4) begin din[0] = pk($urandom); cycle(); end
        idle(); route(0, 2); route(3, 2); vin[2] = 1'b1; din[2] = pk(32'hC0DE0002);
        #1 chk("mc_blocked", if4.o_in_ready[2], 1'b0);
        cycle();
        chk("mc_no_write0", if4.o_out_valid[0], 1'b0);
        ordy[3] = 1'b1;
        cycle();
        ordy[3] = 1'b0;
        #1 chk("mc_open", if4.o_in_ready[2], 1'b1);
        cycle();
        vin = '0;
        chk("mc_out0_data", if4.o_data[0], 32'hC0DE0002);
        cycle();
        drain();

        // Multi-hot select on output 1.
        idle(); sel[1] = 4'b0110; vin = '1;
        for (int n = 0; n < N; n++) din[n] = pk($urandom);
        #1 chk("inv_rdy", if4.o_in_ready, 4'b0000);
        cycle();
        idle();
        chk("inv_no_write", if4.o_out_valid[1], 1'b0);
`ifdef LIB_SWITCH_SEL_CHECK_EN
        chk("inv_sel_err1", err4[1], 1'b1);
        chk("inv_sel_err_cnt", ecnt4, 16'd1);
`endif
        cycle();

        // Reset with two entries queued on output 1.
        idle(); route(1, 3); vin[3] = 1'b1;
        repeat (2) begin din[3] = pk($urandom); cycle(); end
        idle(); reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk("rst_valid", if4.o_out_valid, 4'b0000);
        chk("rst_data1", if4.o_data[1], 32'h0);
        route(1, 3); vin[3] = 1'b1; din[3] = pk(32'h0BADCAFE);
        cycle();
        idle();
        chk("post_rst_data", if4.o_data[1], 32'h0BADCAFE);
        cycle();
        drain();

        // Random traffic: low pop rate first to exercise full FIFOs, then higher.
        for (int c = 0; c < 3000; c++) begin
            pct = (c < 1500) ? 30 : 70;
            reset_n = ($urandom_range(0, 299) != 0);
            for (int m = 0; m < M; m++) begin
                r = $urandom_range(0, 99);
                if (r < 70)      route(m, $urandom_range(0, N-1));
                else if (r < 85) sel[m] = '0;
                else             sel[m] = N'($urandom);
                ordy[m] = ($urandom_range(0, 99) < pct);
            end
            for (int n = 0; n < N; n++) begin
                vin[n] = ($urandom_range(0, 99) < 60);
                din[n] = pk($urandom);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
